// File: rtl/digital_signal_pkg.sv
// Shared types and the SECDED Hamming(12,8)+overall-parity encoder for the signal encoder/decoder pair.
package digital_signal_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CODE_W = 13;

  typedef logic [DATA_W-1:0] raw_word_t;
  typedef logic [CODE_W-1:0] code_word_t;

  typedef enum logic {
    ST_SYNC,
    ST_DATA
  } enc_state_t;

  // code[12:1] are Hamming positions 12..1, code[0] is overall even parity
  function automatic code_word_t secded_encode(input raw_word_t d);
    logic [12:1] h;
    h[3]  = d[0];
    h[5]  = d[1];
    h[6]  = d[2];
    h[7]  = d[3];
    h[9]  = d[4];
    h[10] = d[5];
    h[11] = d[6];
    h[12] = d[7];
    h[1]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    h[2]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    h[4]  = d[1] ^ d[2] ^ d[3] ^ d[7];
    h[8]  = d[4] ^ d[5] ^ d[6] ^ d[7];
    return {h, ^h};
  endfunction

endpackage

// File: rtl/digital_signal_encoder.sv
// Framed SECDED stream encoder: SYNC_WORD, then FRAME_LEN codewords, repeat; registered valid/ready output.
// Optional ENC_ERR_INJECT_EN adds a single-bit error injection port pair for decoder testing.
module digital_signal_encoder
  import digital_signal_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 16,
  parameter code_word_t  SYNC_WORD = 13'h1FFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] raw_data_in,
  input  logic              raw_valid_in,
  output logic              raw_ready_out,
`ifdef ENC_ERR_INJECT_EN
  input  logic              inject_en_in,
  input  logic [3:0]        inject_pos_in,
`endif
  output logic [CODE_W-1:0] encoded_data_out,
  output logic              enc_valid_out,
  input  logic              enc_ready_in,
  output logic              enc_sync_out
);

  localparam int unsigned CNT_W = 8;

  enc_state_t       state_q, state_d;
  logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
  code_word_t       code_q, code_d;
  logic             valid_q, valid_d;
  logic             sync_q, sync_d;
  logic             slot_free;
  code_word_t       enc_word;

  // Codeword for the incoming raw word, with optional deliberate bit flip
  always_comb begin
    enc_word = secded_encode(raw_data_in);
`ifdef ENC_ERR_INJECT_EN
    if (inject_en_in && (inject_pos_in <= 4'd12)) begin
      enc_word = enc_word ^ (code_word_t'(1) << inject_pos_in);
    end
`endif
  end

  // Next-state and output-register logic
  always_comb begin
    state_d       = state_q;
    data_cnt_d    = data_cnt_q;
    code_d        = code_q;
    valid_d       = valid_q;
    sync_d        = sync_q;
    raw_ready_out = 1'b0;
    slot_free     = !valid_q || enc_ready_in;

    case (state_q)
      ST_SYNC: begin
        if (slot_free) begin
          code_d     = SYNC_WORD;
          sync_d     = 1'b1;
          valid_d    = 1'b1;
          data_cnt_d = '0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        raw_ready_out = slot_free;
        if (slot_free && raw_valid_in) begin
          code_d     = enc_word;
          sync_d     = 1'b0;
          valid_d    = 1'b1;
          data_cnt_d = data_cnt_q + CNT_W'(1);
          if (data_cnt_d == CNT_W'(FRAME_LEN)) begin
            state_d = ST_SYNC;
          end
        end else if (slot_free) begin
          valid_d = 1'b0;
          sync_d  = 1'b0;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_SYNC;
      data_cnt_q <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      sync_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_cnt_q <= data_cnt_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      sync_q     <= sync_d;
    end
  end

  assign encoded_data_out = code_q;
  assign enc_valid_out    = valid_q;
  assign enc_sync_out     = sync_q;

endmodule
